// File: rtl/dnn_batch_run_driver.sv
// Batch driver/profiler for a start/done accelerator: back-to-back runs, gap, timeout, latency stats, grant counters.
// Optional DNN_DRIVER_AUTOSTART_EN: launch one DEFAULT_RUNS batch (no timeout) right after reset release.
module dnn_batch_run_driver #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned RUN_W        = 16,
    parameter int unsigned CYC_W        = 64,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned DEFAULT_RUNS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [RUN_W-1:0]        run_count_cfg,
    input  logic [CYC_W-1:0]        timeout_cfg,
    output logic                    acc_start,
    input  logic                    acc_done,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH-1:0]       req_grant,
    output logic                    busy,
    output logic                    batch_done,
    output logic                    timeout_err,
    output logic [RUN_W-1:0]        runs_completed,
    output logic [CYC_W-1:0]        last_cycles,
    output logic [CYC_W-1:0]        min_cycles,
    output logic [CYC_W-1:0]        max_cycles,
    output logic [CYC_W-1:0]        total_cycles,
    output logic [NUM_CH*CNT_W-1:0] req_count
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t             state;
    logic [RUN_W-1:0]   run_target;
    logic [CYC_W-1:0]   tmo;
    logic [CYC_W-1:0]   rc;
    logic [GAP_W-1:0]   gap_cnt;

    logic               auto_go;
    logic               batch_start;
    logic [RUN_W-1:0]   start_runs;
    logic [CYC_W-1:0]   start_tmo;
    logic [CYC_W-1:0]   lat;
    logic [CYC_W:0]     sum;
    logic [CYC_W-1:0]   total_next;
    logic [RUN_W-1:0]   runs_next;

`ifdef DNN_DRIVER_AUTOSTART_EN
    // One-shot request armed by reset, consumed on the first post-reset cycle.
    logic auto_pend;

    always_ff @(posedge clk) begin
        if (rst) auto_pend <= 1'b1;
        else     auto_pend <= 1'b0;
    end

    assign auto_go = auto_pend & (state == S_IDLE);
`else
    assign auto_go = 1'b0;
`endif

    always_comb begin
        batch_start = (state == S_IDLE) & (go | auto_go);
        start_runs  = auto_go ? RUN_W'(DEFAULT_RUNS) : run_count_cfg;
        start_tmo   = auto_go ? '0 : timeout_cfg;
        lat         = rc + CYC_W'(1);
        sum         = {1'b0, total_cycles} + {1'b0, lat};
        total_next  = sum[CYC_W] ? '1 : sum[CYC_W-1:0];
        runs_next   = runs_completed + RUN_W'(1);
    end

    // Batch sequencer and latency statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            run_target     <= '0;
            tmo            <= '0;
            rc             <= '0;
            gap_cnt        <= '0;
            acc_start      <= 1'b0;
            busy           <= 1'b0;
            batch_done     <= 1'b0;
            timeout_err    <= 1'b0;
            runs_completed <= '0;
            last_cycles    <= '0;
            min_cycles     <= '1;
            max_cycles     <= '0;
            total_cycles   <= '0;
        end else begin
            acc_start  <= 1'b0;
            batch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (batch_start) begin
                        run_target     <= start_runs;
                        tmo            <= start_tmo;
                        busy           <= 1'b1;
                        timeout_err    <= 1'b0;
                        runs_completed <= '0;
                        last_cycles    <= '0;
                        min_cycles     <= '1;
                        max_cycles     <= '0;
                        total_cycles   <= '0;
                        if (start_runs == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state     <= S_START;
                            acc_start <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    rc    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (acc_done) begin
                        last_cycles    <= lat;
                        total_cycles   <= total_next;
                        runs_completed <= runs_next;
                        if (lat < min_cycles) min_cycles <= lat;
                        if (lat > max_cycles) max_cycles <= lat;
                        if (runs_next == run_target) begin
                            state <= S_FINISH;
                        end else if (GAP_CYCLES == 0) begin
                            state     <= S_START;
                            acc_start <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end else if ((tmo != '0) && (lat == tmo)) begin
                        timeout_err <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        rc <= lat;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state     <= S_START;
                        acc_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_FINISH: begin
                    batch_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel saturating granted-request counters, cleared at batch start.
    always_ff @(posedge clk) begin
        if (rst || batch_start) begin
            req_count <= '0;
        end else if (busy) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (req_valid[i] && req_grant[i] && (req_count[i*CNT_W +: CNT_W] != '1)) begin
                    req_count[i*CNT_W +: CNT_W] <= req_count[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_batch_run_driver.sv
// Directed self-checking bench for dnn_batch_run_driver (default build, GAP_CYCLES=4).
module tb_dnn_batch_run_driver;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned RUN_W  = 16;
    localparam int unsigned CYC_W  = 64;
    localparam int unsigned CNT_W  = 32;
    localparam int          GAP    = 4;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    go;
    logic [RUN_W-1:0]        run_count_cfg;
    logic [CYC_W-1:0]        timeout_cfg;
    logic                    acc_start;
    logic                    acc_done;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH-1:0]       req_grant;
    logic                    busy;
    logic                    batch_done;
    logic                    timeout_err;
    logic [RUN_W-1:0]        runs_completed;
    logic [CYC_W-1:0]        last_cycles;
    logic [CYC_W-1:0]        min_cycles;
    logic [CYC_W-1:0]        max_cycles;
    logic [CYC_W-1:0]        total_cycles;
    logic [NUM_CH*CNT_W-1:0] req_count;

    dnn_batch_run_driver #(
        .NUM_CH(NUM_CH), .RUN_W(RUN_W), .CYC_W(CYC_W), .CNT_W(CNT_W),
        .GAP_CYCLES(GAP), .DEFAULT_RUNS(1)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .run_count_cfg(run_count_cfg),
        .timeout_cfg(timeout_cfg), .acc_start(acc_start), .acc_done(acc_done),
        .req_valid(req_valid), .req_grant(req_grant), .busy(busy),
        .batch_done(batch_done), .timeout_err(timeout_err),
        .runs_completed(runs_completed), .last_cycles(last_cycles),
        .min_cycles(min_cycles), .max_cycles(max_cycles),
        .total_cycles(total_cycles), .req_count(req_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          runs;
        int          tmo;
        int          lat0;
        int          lat1;
        int          lat2;
        int          starts;
        int          rc;
        logic [63:0] last;
        logic [63:0] mn;
        logic [63:0] mx;
        logic [63:0] total;
        int          terr;
        int          done_cyc;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one batch, answering each acc_start with acc_done after the vector's latency (0 = never).
    task automatic apply(input int idx);
        vec_t v;
        int cyc, starts, cnt, done_cyc, last_done, gap_bad, lat;
        v = vecs[idx];
        go = 1'b1;
        run_count_cfg = RUN_W'(v.runs);
        timeout_cfg = CYC_W'(v.tmo);
        cyc = 0; starts = 0; cnt = 0; done_cyc = -1; last_done = -1; gap_bad = 0;
        for (int k = 0; k < 500 && done_cyc < 0; k++) begin
            tick();
            cyc++;
            go = 1'b0;
            acc_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    acc_done = 1'b1;
                    last_done = cyc;
                end
            end
            if (acc_start) begin
                starts++;
                if (last_done >= 0 && (cyc - last_done) != GAP + 1) gap_bad++;
                lat = (starts == 1) ? v.lat0 : (starts == 2) ? v.lat1 : (starts == 3) ? v.lat2 : 0;
                cnt = lat;
            end
            if (batch_done) done_cyc = cyc;
        end
        acc_done = 1'b0;
        chk($sformatf("v%0d.batch_done_cycle", idx), 64'(done_cyc), 64'(v.done_cyc));
        chk($sformatf("v%0d.start_pulses", idx), 64'(starts), 64'(v.starts));
        chk($sformatf("v%0d.gap_errors", idx), 64'(gap_bad), 64'd0);
        chk($sformatf("v%0d.runs_completed", idx), 64'(runs_completed), 64'(v.rc));
        chk($sformatf("v%0d.last_cycles", idx), last_cycles, v.last);
        chk($sformatf("v%0d.min_cycles", idx), min_cycles, v.mn);
        chk($sformatf("v%0d.max_cycles", idx), max_cycles, v.mx);
        chk($sformatf("v%0d.total_cycles", idx), total_cycles, v.total);
        chk($sformatf("v%0d.timeout_err", idx), 64'(timeout_err), 64'(v.terr));
        chk($sformatf("v%0d.busy_at_done", idx), 64'(busy), 64'd0);
        tick();
        chk($sformatf("v%0d.batch_done_single", idx), 64'(batch_done), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".acc_start"}, 64'(acc_start), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".batch_done"}, 64'(batch_done), 64'd0);
        chk({tag, ".timeout_err"}, 64'(timeout_err), 64'd0);
        chk({tag, ".runs_completed"}, 64'(runs_completed), 64'd0);
        chk({tag, ".last_cycles"}, last_cycles, 64'd0);
        chk({tag, ".min_cycles"}, min_cycles, ONES);
        chk({tag, ".max_cycles"}, max_cycles, 64'd0);
        chk({tag, ".total_cycles"}, total_cycles, 64'd0);
        chk({tag, ".req_count"}, 64'(req_count), 64'd0);
    endtask

    initial begin
        int starts;
        int extra;
        //         runs tmo l0 l1 l2 starts rc last   min    max    total  terr done
        vecs[0] = '{1, 0, 10, 0, 0, 1, 1, 64'd10, 64'd10, 64'd10, 64'd10, 0, 13};
        vecs[1] = '{3, 0, 5, 12, 7, 3, 3, 64'd7, 64'd5, 64'd12, 64'd24, 0, 37};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 64'd0, ONES, 64'd0, 64'd0, 0, 2};
        vecs[3] = '{2, 20, 0, 0, 0, 1, 0, 64'd0, ONES, 64'd0, 64'd0, 1, 23};
        vecs[4] = '{2, 8, 8, 3, 0, 2, 2, 64'd3, 64'd3, 64'd8, 64'd11, 0, 19};
        vecs[5] = '{2, 6, 4, 0, 0, 2, 1, 64'd4, 64'd4, 64'd4, 64'd4, 1, 18};
        vecs[6] = '{1, 0, 1, 0, 0, 1, 1, 64'd1, 64'd1, 64'd1, 64'd1, 0, 4};

        rst = 1'b1; go = 1'b0; acc_done = 1'b0;
        run_count_cfg = '0; timeout_cfg = '0; req_valid = '0; req_grant = '0;
        tick(); tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) apply(i);

        // Request counters: ch0 granted 9 cycles, ch1 granted 3 cycles, idle grants ignored.
        go = 1'b1; run_count_cfg = RUN_W'(1); timeout_cfg = '0;
        tick();
        go = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (c <= 6)       begin req_valid = 2'b11; req_grant = 2'b01; end
            else if (c <= 9)  begin req_valid = 2'b11; req_grant = 2'b11; end
            else if (c <= 11) begin req_valid = 2'b00; req_grant = 2'b11; end
            else              begin req_valid = 2'b00; req_grant = 2'b00; end
            tick();
        end
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        for (int k = 0; k < 10 && !batch_done; k++) tick();
        chk("req.batch_done", 64'(batch_done), 64'd1);
        chk("req.last_cycles", last_cycles, 64'd19);
        chk("req.ch0", 64'(req_count[0 +: CNT_W]), 64'd9);
        chk("req.ch1", 64'(req_count[CNT_W +: CNT_W]), 64'd3);
        req_valid = 2'b11; req_grant = 2'b11;
        tick(); tick(); tick();
        req_valid = 2'b00; req_grant = 2'b00;
        chk("req.ch0_idle", 64'(req_count[0 +: CNT_W]), 64'd9);
        chk("req.ch1_idle", 64'(req_count[CNT_W +: CNT_W]), 64'd3);

        // Reset during WAIT of run 2 of 3.
        go = 1'b1; run_count_cfg = RUN_W'(3); timeout_cfg = '0;
        tick();
        go = 1'b0;
        starts = 0;
        for (int c = 1; c < 15; c++) begin
            acc_done = (c == 6);
            if (acc_start) starts++;
            tick();
        end
        acc_done = 1'b0;
        chk("rst.starts_before", 64'(starts), 64'd2);
        chk("rst.runs_before", 64'(runs_completed), 64'd1);
        chk("rst.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (acc_start || busy) extra++;
        end
        chk("rst.no_restart", 64'(extra), 64'd0);

        apply(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
